// File: rtl/lcd_bus_receiver_if.sv
// HD44780 write bus as seen from the bus master (driver) and the receiver.
// The master drives all four signals; the receiver only samples them.
interface lcd_bus_receiver_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (output LCD_EN, LCD_RS, LCD_RW, LCD_DATA);
  modport slave  (input  LCD_EN, LCD_RS, LCD_RW, LCD_DATA);
endinterface

// File: rtl/lcd_bus_receiver.sv
// Passive HD44780 bus receiver: tracks init, address counter and a 16x2 shadow of written text.
// A strobe takes effect one cycle after the EN falling edge; rd_char has 1-cycle latency; no backpressure.
module lcd_bus_receiver (
  input  logic                     CLK_400Hz,
  input  logic                     resetn,
  lcd_bus_receiver_if.slave        bus,
  input  logic [4:0]               rd_addr,
  output logic [7:0]               rd_char,
  output logic                     ready,
  output logic                     display_on,
  output logic                     cur_line,
  output logic [3:0]               cur_col,
  output logic                     addr_oob,
  output logic                     frame_done,
  output logic [7:0]               frame_count,
  output logic                     err_protocol
);

  typedef enum logic [1:0] {
    S_FS    = 2'd0,
    S_CFG   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  fs_cnt, fs_cnt_nxt;
  logic [31:0] valid, valid_nxt;
  logic        inc, inc_nxt;
  logic        line_nxt;
  logic [3:0]  col_nxt;
  logic        oob_nxt;
  logic        disp_nxt;
  logic        fd_nxt;
  logic [7:0]  fc_nxt;
  logic        err_nxt;
  logic        dirty, dirty_nxt;

  logic        en_q, rs_q, rw_q;
  logic [7:0]  data_q;

  logic        strobe;
  logic        wr_en;
  logic        exec;
  logic        frame_hit;
  logic [4:0]  wr_idx;
  logic [7:0]  mem [32];

  // The bus fields are taken from the cycle before EN fell, where they are known stable.
  assign strobe = en_q & ~bus.LCD_EN;
  assign wr_idx = {cur_line, cur_col};
  assign ready  = (state == S_READY);

  always_comb begin
    state_nxt  = state;
    fs_cnt_nxt = fs_cnt;
    valid_nxt  = valid;
    inc_nxt    = inc;
    line_nxt   = cur_line;
    col_nxt    = cur_col;
    oob_nxt    = addr_oob;
    disp_nxt   = display_on;
    fd_nxt     = 1'b0;
    fc_nxt     = frame_count;
    err_nxt    = err_protocol;
    dirty_nxt  = dirty;
    wr_en      = 1'b0;
    exec       = 1'b0;
    frame_hit  = 1'b0;

    if (strobe) begin
      if (rw_q) begin
        err_nxt = 1'b1;
      end else if (rs_q) begin
        if (state != S_READY) begin
          err_nxt = 1'b1;
        end else if (!addr_oob) begin
          wr_en            = 1'b1;
          valid_nxt[wr_idx] = 1'b1;
          dirty_nxt        = 1'b1;
          // Running off either end of the line parks the column and flags out-of-bounds.
          if (inc) begin
            if (cur_col == 4'd15) oob_nxt = 1'b1;
            else                  col_nxt = cur_col + 4'd1;
          end else begin
            if (cur_col == 4'd0)  oob_nxt = 1'b1;
            else                  col_nxt = cur_col - 4'd1;
          end
        end
      end else begin
        case (state)
          S_FS: begin
            if (data_q == 8'h38) begin
              if (fs_cnt != 2'd3) fs_cnt_nxt = fs_cnt + 2'd1;
            end else if (fs_cnt != 2'd3) begin
              err_nxt    = 1'b1;
              fs_cnt_nxt = 2'd0;
            end else begin
              exec      = 1'b1;
              state_nxt = S_CFG;
            end
          end
          S_CFG: begin
            exec = 1'b1;
            if (data_q[7:2] == 6'b000001) state_nxt = S_READY;
          end
          default: exec = 1'b1;
        endcase

        if (exec) begin
          casez (data_q)
            8'b1???????: begin
              line_nxt  = data_q[6];
              col_nxt   = data_q[3:0];
              oob_nxt   = |data_q[5:4];
              frame_hit = (data_q == 8'h80);
            end
            8'b001?????: begin
              if (data_q != 8'h38) err_nxt = 1'b1;
            end
            8'b00001???: disp_nxt = data_q[2];
            8'b000001??: inc_nxt  = data_q[1];
            8'b0000001?: begin
              line_nxt  = 1'b0;
              col_nxt   = 4'd0;
              oob_nxt   = 1'b0;
              frame_hit = 1'b1;
            end
            8'b00000001: begin
              valid_nxt = '0;
              line_nxt  = 1'b0;
              col_nxt   = 4'd0;
              oob_nxt   = 1'b0;
            end
            default: ;
          endcase
        end

        if (frame_hit && dirty) begin
          fd_nxt    = 1'b1;
          fc_nxt    = frame_count + 8'd1;
          dirty_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_400Hz) begin
    if (!resetn) begin
      state        <= S_FS;
      fs_cnt       <= 2'd0;
      valid        <= '0;
      inc          <= 1'b1;
      cur_line     <= 1'b0;
      cur_col      <= 4'd0;
      addr_oob     <= 1'b0;
      display_on   <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= 8'd0;
      err_protocol <= 1'b0;
      dirty        <= 1'b0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      data_q       <= 8'd0;
      rd_char      <= 8'h20;
    end else begin
      state        <= state_nxt;
      fs_cnt       <= fs_cnt_nxt;
      valid        <= valid_nxt;
      inc          <= inc_nxt;
      cur_line     <= line_nxt;
      cur_col      <= col_nxt;
      addr_oob     <= oob_nxt;
      display_on   <= disp_nxt;
      frame_done   <= fd_nxt;
      frame_count  <= fc_nxt;
      err_protocol <= err_nxt;
      dirty        <= dirty_nxt;
      en_q         <= bus.LCD_EN;
      rs_q         <= bus.LCD_RS;
      rw_q         <= bus.LCD_RW;
      data_q       <= bus.LCD_DATA;
      rd_char      <= valid[rd_addr] ? mem[rd_addr] : 8'h20;
    end
  end

  // Character storage needs no reset: the valid vector masks stale contents.
  always_ff @(posedge CLK_400Hz) begin
    if (resetn && wr_en) mem[wr_idx] <= data_q;
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: table-driven init/text vectors plus frame, bounds, error and reset sequences.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic       ready, display_on, cur_line, addr_oob, frame_done, err_protocol;
  logic [3:0] cur_col;
  logic [7:0] frame_count;

  int errors    = 0;
  int checks    = 0;
  int fd_cycles = 0;

  lcd_bus_receiver_if bif();

  lcd_bus_receiver dut (
    .CLK_400Hz    (clk),
    .resetn       (resetn),
    .bus          (bif),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .ready        (ready),
    .display_on   (display_on),
    .cur_line     (cur_line),
    .cur_col      (cur_col),
    .addr_oob     (addr_oob),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cycles++;

  typedef struct {
    logic       rs;
    logic       rw;
    logic [7:0] d;
    logic       rdy;
    logic       disp;
    logic       line;
    logic [3:0] col;
    logic       oob;
    logic       err;
  } vec_t;

  vec_t       vecs [0:17];
  logic [7:0] patient [0:7];
  logic [7:0] exp_ch;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic rs, input logic [7:0] d, input logic rw);
    bif.LCD_RS   = rs;
    bif.LCD_RW   = rw;
    bif.LCD_DATA = d;
    bif.LCD_EN   = 1'b1;
    tick();
    bif.LCD_EN   = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] exp, input string name);
    rd_addr = a;
    tick();
    chk(name, 32'(rd_char), 32'(exp));
  endtask

  task automatic do_reset();
    bif.LCD_EN = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_init();
    for (int i = 0; i < 4; i++) strobe(1'b0, 8'h38, 1'b0);
    strobe(1'b0, 8'h08, 1'b0);
    strobe(1'b0, 8'h01, 1'b0);
    strobe(1'b0, 8'h0C, 1'b0);
    strobe(1'b0, 8'h06, 1'b0);
    chk("init_ready", 32'(ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"},       32'(ready),        32'd0);
    chk({tag, ".display_on"},  32'(display_on),   32'd0);
    chk({tag, ".cur_line"},    32'(cur_line),     32'd0);
    chk({tag, ".cur_col"},     32'(cur_col),      32'd0);
    chk({tag, ".addr_oob"},    32'(addr_oob),     32'd0);
    chk({tag, ".frame_done"},  32'(frame_done),   32'd0);
    chk({tag, ".frame_count"}, 32'(frame_count),  32'd0);
    chk({tag, ".err"},         32'(err_protocol), 32'd0);
    chk({tag, ".rd_char"},     32'(rd_char),      32'h20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    patient = '{8'h50, 8'h61, 8'h74, 8'h69, 8'h65, 8'h6E, 8'h74, 8'h3A};
    for (int i = 0; i < 4; i++) vecs[i] = '{1'b0, 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h0C, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      vecs[8+k] = '{1'b1, 1'b0, patient[k], 1'b1, 1'b1, 1'b0, 4'(k + 1), 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'hC0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 8'h50, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};

    bif.LCD_EN = 1'b0; bif.LCD_RS = 1'b0; bif.LCD_RW = 1'b0; bif.LCD_DATA = 8'h00;
    rd_addr = 5'd0;
    resetn  = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // Init sequence followed by "Patient:" on line 0 and 'P' on line 1.
    for (int i = 0; i < 18; i++) begin
      strobe(vecs[i].rs, vecs[i].d, vecs[i].rw);
      chk($sformatf("vec%0d.ready", i),    32'(ready),        32'(vecs[i].rdy));
      chk($sformatf("vec%0d.display", i),  32'(display_on),   32'(vecs[i].disp));
      chk($sformatf("vec%0d.line", i),     32'(cur_line),     32'(vecs[i].line));
      chk($sformatf("vec%0d.col", i),      32'(cur_col),      32'(vecs[i].col));
      chk($sformatf("vec%0d.oob", i),      32'(addr_oob),     32'(vecs[i].oob));
      chk($sformatf("vec%0d.err", i),      32'(err_protocol), 32'(vecs[i].err));
    end
    for (int a = 0; a < 32; a++) begin
      exp_ch = 8'h20;
      if (a < 8)   exp_ch = patient[a];
      if (a == 16) exp_ch = 8'h50;
      rd_chk(5'(a), exp_ch, $sformatf("shadow[%0d]", a));
    end

    // Frames: first one closes the text above, then an empty 0x80, then 255 more.
    chk("fd_before_frames", 32'(fd_cycles), 32'd0);
    strobe(1'b0, 8'h80, 1'b0);
    chk("frame1.pulse", 32'(frame_done), 32'd1);
    tick();
    chk("frame1.pulse_end", 32'(frame_done), 32'd0);
    chk("frame1.count", 32'(frame_count), 32'd1);
    strobe(1'b0, 8'h80, 1'b0);
    chk("frame_empty.no_pulse", 32'(frame_done), 32'd0);
    chk("frame_empty.count", 32'(frame_count), 32'd1);
    for (int i = 1; i < 256; i++) begin
      strobe(1'b1, 8'h41, 1'b0);
      strobe(1'b0, (i == 5) ? 8'h02 : 8'h80, 1'b0);
      if (i == 5) chk("frame_home.pulse", 32'(frame_done), 32'd1);
    end
    tick();
    chk("frames.pulse_cycles", 32'(fd_cycles), 32'd256);
    chk("frames.count_wrap", 32'(frame_count), 32'd0);
    chk("frames.err", 32'(err_protocol), 32'd0);

    // Incrementing off the right edge, then decrementing off the left edge.
    strobe(1'b0, 8'h01, 1'b0);
    for (int k = 0; k < 17; k++) begin
      strobe(1'b1, 8'(8'h61 + k), 1'b0);
      if (k == 14) begin
        chk("oob.w15.col", 32'(cur_col),  32'd15);
        chk("oob.w15.oob", 32'(addr_oob), 32'd0);
      end
      if (k == 15) begin
        chk("oob.w16.col", 32'(cur_col),  32'd15);
        chk("oob.w16.oob", 32'(addr_oob), 32'd1);
      end
    end
    chk("oob.w17.col", 32'(cur_col),      32'd15);
    chk("oob.w17.err", 32'(err_protocol), 32'd0);
    rd_chk(5'd15, 8'h70, "oob.cell15");
    rd_chk(5'd16, 8'h20, "oob.cell16_untouched");
    rd_chk(5'd0,  8'h61, "oob.cell0");
    strobe(1'b0, 8'h04, 1'b0);
    strobe(1'b0, 8'hC0, 1'b0);
    chk("dec.line", 32'(cur_line), 32'd1);
    chk("dec.oob_clear", 32'(addr_oob), 32'd0);
    strobe(1'b1, 8'h5A, 1'b0);
    chk("dec.oob", 32'(addr_oob), 32'd1);
    chk("dec.col", 32'(cur_col),  32'd0);
    rd_chk(5'd16, 8'h5A, "dec.cell16");
    strobe(1'b0, 8'h90, 1'b0);
    chk("ddram90.oob",  32'(addr_oob), 32'd1);
    chk("ddram90.line", 32'(cur_line), 32'd0);
    strobe(1'b1, 8'h21, 1'b0);
    rd_chk(5'd0, 8'h61, "ddram90.write_dropped");
    strobe(1'b0, 8'h14, 1'b0);
    strobe(1'b0, 8'h48, 1'b0);
    chk("ignored_cmds.err", 32'(err_protocol), 32'd0);
    strobe(1'b0, 8'h30, 1'b0);
    chk("funcset30.err", 32'(err_protocol), 32'd1);

    // Data write before init.
    do_reset();
    chk("preinit.err_clear", 32'(err_protocol), 32'd0);
    strobe(1'b1, 8'h51, 1'b0);
    chk("preinit.err", 32'(err_protocol), 32'd1);
    chk("preinit.ready", 32'(ready), 32'd0);
    rd_chk(5'd0, 8'h20, "preinit.cell0");

    // Read strobes are rejected and change nothing.
    do_reset();
    do_init();
    strobe(1'b1, 8'h51, 1'b1);
    chk("rw1.err", 32'(err_protocol), 32'd1);
    chk("rw1.col", 32'(cur_col), 32'd0);
    rd_chk(5'd0, 8'h20, "rw1.cell0");
    strobe(1'b0, 8'hC5, 1'b1);
    chk("rw1cmd.line", 32'(cur_line), 32'd0);
    chk("rw1cmd.col", 32'(cur_col), 32'd0);

    // Reset mid-frame with EN high, released as EN falls.
    do_reset();
    do_init();
    strobe(1'b1, 8'h4B, 1'b0);
    strobe(1'b0, 8'h80, 1'b0);
    chk("midreset.pre_count", 32'(frame_count), 32'd1);
    strobe(1'b1, 8'h4C, 1'b0);
    bif.LCD_RS = 1'b1; bif.LCD_RW = 1'b0; bif.LCD_DATA = 8'h4E; bif.LCD_EN = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    bif.LCD_EN = 1'b0;
    tick();
    tick();
    rd_addr = 5'd0;
    tick();
    chk_reset_outputs("midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have port CLK_400Hz, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port LCD_EN, input, 1 bit: HD44780 enable strobe from the bus master.
REQ-004 SHALL have port LCD_RS, input, 1 bit: 0 = command, 1 = data.
REQ-005 SHALL have port LCD_RW, input, 1 bit: 0 = write; 1 is illegal.
REQ-006 SHALL have port LCD_DATA, input, 8 bits: bus data.
REQ-007 SHALL have port rd_addr, input, 5 bits: shadow read index, {line, col[3:0]}.
REQ-008 SHALL have port rd_char, output, 8 bits: shadow character at rd_addr.
REQ-009 SHALL have port ready, output, 1 bit: init sequence complete.
REQ-010 SHALL have port display_on, output, 1 bit: display-control D bit.
REQ-011 SHALL have port cur_line, output, 1 bit, and port cur_col, output, 4 bits: address counter.
REQ-012 SHALL have port addr_oob, output, 1 bit: address counter outside visible 16x2 window.
REQ-013 SHALL have port frame_done, output, 1 bit: frame-complete pulse.
REQ-014 SHALL have port frame_count, output, 8 bits: count of completed frames.
REQ-015 SHALL have port err_protocol, output, 1 bit: sticky protocol error flag.

Function
REQ-016 SHALL register LCD_EN, LCD_RS, LCD_RW and LCD_DATA each cycle; a strobe SHALL occur on a cycle where registered EN = 1 and current LCD_EN = 0, using the registered RS/RW/DATA values.
REQ-017 SHALL ignore a strobe with RW = 1 (no state change) and set err_protocol.
REQ-018 SHALL implement init FSM states S_FS, S_CFG, S_READY; ready = 1 only in S_READY.
REQ-019 In S_FS, command 0x38 SHALL increment fs_cnt (saturating at 3); any other command with fs_cnt < 3 SHALL set err_protocol and clear fs_cnt; any non-0x38 command with fs_cnt = 3 SHALL be executed and move the FSM to S_CFG.
REQ-020 In S_CFG, an entry-mode command (0x04-0x07) SHALL be executed and move the FSM to S_READY; other commands SHALL be executed and leave the state unchanged.
REQ-021 Function set (0x20-0x3F) other than 0x38 SHALL set err_protocol in any state.
REQ-022 Clear (0x01) SHALL invalidate all 32 shadow cells in one cycle (32-bit valid vector) and set the address counter to line 0, col 0, addr_oob = 0.
REQ-023 Return home (0x02/0x03) SHALL set the address counter to line 0, col 0, addr_oob = 0.
REQ-024 Entry mode SHALL store inc = DATA[1].
REQ-025 Display control (0x08-0x0F) SHALL set display_on = DATA[2].
REQ-026 Set DDRAM address (DATA[7] = 1) SHALL load cur_line = DATA[6] and cur_col = DATA[3:0], and set addr_oob = (DATA[5:4] != 0).
REQ-027 Commands 0x10-0x1F and 0x40-0x7F SHALL be ignored without error.
REQ-028 A data write in S_READY with addr_oob = 0 SHALL store DATA and set the valid bit at {cur_line, cur_col}.
REQ-029 After each such data write, cur_col SHALL step +1 if inc = 1, else -1; stepping past 15 or below 0 SHALL set addr_oob = 1 and leave cur_col unchanged.
REQ-030 A data write with addr_oob = 1 SHALL be dropped without error.
REQ-031 A data write outside S_READY SHALL be dropped and set err_protocol.
REQ-032 rd_char SHALL be registered with 1-cycle latency from rd_addr; an invalid cell SHALL read as 0x20.
REQ-033 When a return home or set-DDRAM-address command to line 0, col 0 (0x80) occurs with at least one data write stored since the previous frame_done, frame_done SHALL pulse for exactly 1 cycle on the cycle after the strobe.
REQ-034 frame_count SHALL increment, wrapping 255 -> 0, on each frame_done pulse.
REQ-035 err_protocol SHALL clear only on reset.

Reset
REQ-036 On resetn = 0 at a clock edge, the following SHALL hold next cycle regardless of any strobe in progress: FSM = S_FS, fs_cnt = 0, all valid bits = 0, inc = 1, cur_line = 0, cur_col = 0, addr_oob = 0, display_on = 0, ready = 0, frame_done = 0, frame_count = 0, err_protocol = 0, rd_char = 0x20, registered EN = 0.
REQ-037 A falling edge of LCD_EN on the first cycle after reset release SHALL NOT count as a strobe.

Verification
REQ-038 SHALL cover: commands 0x38 x4, 0x08, 0x01, 0x0C, 0x06 -> ready = 1, display_on = 1, err_protocol = 0.
REQ-039 SHALL cover: after init, data "Patient:" then command 0xC0, then data 'P' -> rd_addr 0..7 read 0x50..0x3A, rd_addr 16 reads 0x50, all other cells read 0x20.
REQ-040 SHALL cover: a frame of writes followed by 0x80, repeated 256 times -> 256 frame_done pulses of 1 cycle each, frame_count = 0.
REQ-041 SHALL cover: 17 data writes from col 0 -> addr_oob = 1 after the 16th, 17th write dropped, err_protocol = 0.
REQ-042 SHALL cover: a data write before init, or a strobe with RW = 1 -> err_protocol = 1 and the shadow is unchanged.
REQ-043 SHALL cover: resetn = 0 while LCD_EN = 1 mid-frame, released while LCD_EN = 0 -> all outputs at their reset values, frame_count = 0, no strobe counted.
